// File: rtl/rv32_pipe3_core.sv
// rv32_pipe3_core: 3-stage RV32I-subset core (fetch / decode+execute / writeback) with WB->EX forwarding
module rv32_pipe3_core #(
   parameter int unsigned IMEM_AW  = 12,
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter logic [11:0] CSR_IN   = 12'hF00,
   parameter logic [11:0] CSR_OUT  = 12'hF02
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [IMEM_AW-1:0] imem_addr_o,
   input  logic [31:0]        imem_rdata_i,
   input  logic [31:0]        gpio_in_i,
   output logic [31:0]        gpio_out_o,
   output logic               gpio_out_we_o,
   output logic               illegal_o
);
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_SYSTEM = 7'h73;
   localparam logic [31:0] NOP       = 32'h0000_0013;

   logic [31:0] pc_f_q, pc_ex_q;
   logic        ex_valid_q;
   logic [31:0] rf_q [32];
   logic        wb_we_q, wb_gpio_q;
   logic [4:0]  wb_rd_q;
   logic [31:0] wb_res_q, wb_data;
   logic [31:0] gpio_out_q;
   logic        gpio_out_we_q, illegal_q;

   logic [31:0] inst, imm_i, imm_b, imm_j, imm_u;
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic        alt;
   logic [31:0] rs1_v, rs2_v, op_b, alu_res, target;
   logic        taken, redirect, wr_en;
   logic        wb_we_d, wb_gpio_d, gpio_we_d, ill_d;
   logic [31:0] wb_res_d;

   assign imem_addr_o   = pc_f_q[IMEM_AW+1:2];
   assign gpio_out_o    = gpio_out_q;
   assign gpio_out_we_o = gpio_out_we_q;
   assign illegal_o     = illegal_q;

   // A squashed or post-reset slot executes as addi x0,x0,0
   assign inst   = ex_valid_q ? imem_rdata_i : NOP;
   assign opcode = inst[6:0];
   assign rd     = inst[11:7];
   assign f3     = inst[14:12];
   assign rs1    = inst[19:15];
   assign rs2    = inst[24:20];
   assign alt    = inst[30];
   assign imm_i  = {{20{inst[31]}}, inst[31:20]};
   assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   assign imm_u  = {inst[31:12], 12'h000};

   // gpio_in is sampled in WB, so a CSR_IN read forwards the live switch value
   assign wb_data = wb_gpio_q ? gpio_in_i : wb_res_q;
   assign rs1_v   = (wb_we_q && wb_rd_q != 5'd0 && wb_rd_q == rs1) ? wb_data : rf_q[rs1];
   assign rs2_v   = (wb_we_q && wb_rd_q != 5'd0 && wb_rd_q == rs2) ? wb_data : rf_q[rs2];
   assign op_b    = (opcode == OPC_OP) ? rs2_v : imm_i;

   // ALU shared by register and immediate forms; bit 30 selects sub (reg form only) and sra
   always_comb begin
      alu_res = 32'h0;
      case (f3)
         3'b000: alu_res = (opcode == OPC_OP && alt) ? rs1_v - op_b : rs1_v + op_b;
         3'b001: alu_res = rs1_v << op_b[4:0];
         3'b010: alu_res = {31'h0, $signed(rs1_v) < $signed(op_b)};
         3'b011: alu_res = {31'h0, rs1_v < op_b};
         3'b100: alu_res = rs1_v ^ op_b;
         3'b101: alu_res = alt ? 32'($signed(rs1_v) >>> op_b[4:0]) : rs1_v >> op_b[4:0];
         3'b110: alu_res = rs1_v | op_b;
         default: alu_res = rs1_v & op_b;
      endcase
   end

   // Branch condition; reserved funct3 encodings never take
   assign taken = (f3 == 3'b000) ? rs1_v == rs2_v :
                  (f3 == 3'b001) ? rs1_v != rs2_v :
                  (f3 == 3'b100) ? $signed(rs1_v) <  $signed(rs2_v) :
                  (f3 == 3'b101) ? $signed(rs1_v) >= $signed(rs2_v) :
                  (f3 == 3'b110) ? rs1_v <  rs2_v :
                  (f3 == 3'b111) ? rs1_v >= rs2_v : 1'b0;

   // EX decode: WB result selection, redirect resolution and side-effect strobes
   always_comb begin
      wr_en     = 1'b0;
      wb_res_d  = alu_res;
      wb_gpio_d = 1'b0;
      gpio_we_d = 1'b0;
      ill_d     = 1'b0;
      redirect  = 1'b0;
      target    = pc_ex_q + imm_b;
      case (opcode)
         OPC_OP, OPC_OP_IMM: wr_en = 1'b1;
         OPC_LUI: begin
            wr_en    = 1'b1;
            wb_res_d = imm_u;
         end
         OPC_AUIPC: begin
            wr_en    = 1'b1;
            wb_res_d = pc_ex_q + imm_u;
         end
         OPC_BRANCH: redirect = taken;
         OPC_JAL: begin
            wr_en    = 1'b1;
            wb_res_d = pc_ex_q + 32'd4;
            redirect = 1'b1;
            target   = pc_ex_q + imm_j;
         end
         OPC_JALR: begin
            wr_en    = 1'b1;
            wb_res_d = pc_ex_q + 32'd4;
            redirect = 1'b1;
            target   = (rs1_v + imm_i) & ~32'd1;
         end
         OPC_SYSTEM: begin
            if (f3 == 3'b001) begin
               wr_en     = 1'b1;
               wb_res_d  = 32'h0;
               wb_gpio_d = inst[31:20] == CSR_IN;
               gpio_we_d = inst[31:20] == CSR_OUT;
            end else begin
               ill_d = 1'b1;
            end
         end
         default: ill_d = 1'b1;
      endcase
      wb_we_d = wr_en && rd != 5'd0;
   end

   // Fetch PC, EX slot and WB/GPIO/illegal registers; reset discards everything in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_f_q        <= RESET_PC;
         pc_ex_q       <= RESET_PC;
         ex_valid_q    <= 1'b0;
         wb_we_q       <= 1'b0;
         wb_gpio_q     <= 1'b0;
         wb_rd_q       <= 5'd0;
         wb_res_q      <= 32'h0;
         gpio_out_q    <= 32'h0;
         gpio_out_we_q <= 1'b0;
         illegal_q     <= 1'b0;
      end else begin
         pc_ex_q       <= pc_f_q;
         ex_valid_q    <= ~redirect;
         pc_f_q        <= redirect ? target : pc_f_q + 32'd4;
         wb_we_q       <= wb_we_d;
         wb_gpio_q     <= wb_gpio_d;
         wb_rd_q       <= rd;
         wb_res_q      <= wb_res_d;
         gpio_out_we_q <= gpio_we_d;
         illegal_q     <= ill_d;
         if (gpio_we_d) gpio_out_q <= rs1_v;
      end
   end

   // Register file: cleared on reset, written at the end of WB; x0 is never written
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < 32; r++) rf_q[r] <= 32'h0;
      end else if (wb_we_q && wb_rd_q != 5'd0) begin
         rf_q[wb_rd_q] <= wb_data;
      end
   end
endmodule

// File: tb/tb_rv32_pipe3_core.sv
// tb_rv32_pipe3_core: directed + random programs checked cycle-by-cycle against an ISA-level model
module tb_rv32_pipe3_core;
   localparam int AW = 6;
   localparam int NW = 1 << AW;
   localparam logic [31:0] RST_PC = 32'h0;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_rdata = 32'h0;
   logic [31:0]   gpio_in = 32'h0;
   logic [31:0]   gpio_out;
   logic          gpio_out_we, illegal;
   logic [31:0]   mem [NW];

   int n_chk = 0;
   int n_pass = 0;
   int ill_cnt = 0;
   logic [31:0] gpio_log [$];

   logic [31:0] m_rf [32];
   logic [31:0] m_pc, m_ex_pc, exp_gpio;
   logic        m_ex_valid, exp_we, exp_ill;
   logic [4:0]  m_pend;

   rv32_pipe3_core #(.IMEM_AW(AW), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
      .gpio_in_i(gpio_in), .gpio_out_o(gpio_out), .gpio_out_we_o(gpio_out_we), .illegal_o(illegal)
   );

   always #5 clk = ~clk;
   always @(posedge clk) imem_rdata <= mem[imem_addr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
      return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
   endfunction
   function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
   endfunction
   function automatic logic [31:0] enc_b(int off, int rs2, int rs1, int f3);
      logic [12:0] o = 13'(off);
      return {o[12], o[10:5], 5'(rs2), 5'(rs1), 3'(f3), o[4:1], o[11], 7'h63};
   endfunction
   function automatic logic [31:0] enc_j(int off, int rd);
      logic [20:0] o = 21'(off);
      return {o[20], o[10:1], o[11], o[19:12], 5'(rd), 7'h6F};
   endfunction
   function automatic logic [31:0] enc_u(logic [31:0] imm, int rd, logic [6:0] op);
      return {imm[19:0], 5'(rd), op};
   endfunction
   function automatic logic [31:0] enc_csr(int csr, int rs1, int rd);
      return enc_i(csr, rs1, 1, rd, 7'h73);
   endfunction

   function automatic logic [31:0] alu(logic [2:0] f, logic sub_sra, logic [31:0] a, logic [31:0] b);
      case (f)
         3'd0: return sub_sra ? a - b : a + b;
         3'd1: return a << b[4:0];
         3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3: return (a < b) ? 32'd1 : 32'd0;
         3'd4: return a ^ b;
         3'd5: return sub_sra ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic cond(logic [2:0] f, logic [31:0] a, logic [31:0] b);
      case (f)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic m_reset();
      for (int r = 0; r < 32; r++) m_rf[r] = 32'h0;
      m_pc = RST_PC; m_ex_pc = RST_PC; m_ex_valid = 1'b0; m_pend = 5'd0;
      exp_gpio = 32'h0; exp_we = 1'b0; exp_ill = 1'b0;
   endtask

   task automatic wr(logic [4:0] rd, logic [31:0] v);
      if (rd != 5'd0) m_rf[rd] = v;
   endtask

   // Architectural step for the coming clock edge: one instruction (or bubble) completes
   task automatic m_step();
      logic [31:0] i, a, b, immi, immb, immj, immu, tgt;
      logic red;
      if (!rst_n) begin
         m_reset();
         return;
      end
      if (m_pend != 5'd0) m_rf[m_pend] = gpio_in;
      m_pend = 5'd0;
      exp_we = 1'b0; exp_ill = 1'b0; red = 1'b0; tgt = 32'h0;
      if (m_ex_valid) begin
         i = mem[m_ex_pc[AW+1:2]];
         a = m_rf[i[19:15]];
         b = m_rf[i[24:20]];
         immi = {{20{i[31]}}, i[31:20]};
         immb = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         immj = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         immu = {i[31:12], 12'h0};
         case (i[6:0])
            7'h13: wr(i[11:7], alu(i[14:12], i[14:12] == 3'd5 && i[30], a, immi));
            7'h33: wr(i[11:7], alu(i[14:12], i[30], a, b));
            7'h37: wr(i[11:7], immu);
            7'h17: wr(i[11:7], m_ex_pc + immu);
            7'h63: if (cond(i[14:12], a, b)) begin red = 1'b1; tgt = m_ex_pc + immb; end
            7'h6F: begin red = 1'b1; tgt = m_ex_pc + immj; wr(i[11:7], m_ex_pc + 4); end
            7'h67: begin red = 1'b1; tgt = (a + immi) & ~32'd1; wr(i[11:7], m_ex_pc + 4); end
            7'h73: begin
               if (i[14:12] == 3'd1) begin
                  if (i[31:20] == 12'hF02) begin exp_gpio = a; exp_we = 1'b1; end
                  if (i[31:20] == 12'hF00) m_pend = i[11:7];
                  else wr(i[11:7], 32'h0);
               end else exp_ill = 1'b1;
            end
            default: exp_ill = 1'b1;
         endcase
      end
      m_ex_pc = m_pc;
      m_ex_valid = !red;
      m_pc = red ? tgt : m_pc + 4;
   endtask

   task automatic cycle(input logic rv, input logic [31:0] gin);
      logic [31:0] pcw;
      @(negedge clk);
      pcw = 32'(m_pc[AW+1:2]);
      chk("imem_addr", 32'(imem_addr), pcw);
      chk("gpio_out", gpio_out, exp_gpio);
      chk("gpio_out_we", 32'(gpio_out_we), 32'(exp_we));
      chk("illegal", 32'(illegal), 32'(exp_ill));
      if (gpio_out_we) gpio_log.push_back(gpio_out);
      if (illegal) ill_cnt++;
      rst_n = rv;
      gpio_in = gin;
      m_step();
   endtask

   function automatic logic [31:0] gen();
      int k = int'($urandom_range(0, 99));
      int rd = int'($urandom_range(0, 7));
      int rs1 = int'($urandom_range(0, 7));
      int rs2 = int'($urandom_range(0, 7));
      int f3 = int'($urandom_range(0, 7));
      int off = (int'($urandom_range(0, 16)) - 8) * 4;
      logic [31:0] r = $urandom;
      if (k < 30) begin
         if (f3 == 1) return enc_i(int'($urandom_range(0, 31)), rs1, f3, rd, 7'h13);
         if (f3 == 5) return enc_i(int'($urandom_range(0, 1)) * 1024 + int'($urandom_range(0, 31)), rs1, f3, rd, 7'h13);
         return enc_i(int'($urandom_range(0, 4095)), rs1, f3, rd, 7'h13);
      end
      if (k < 45) return enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32 : 0, rs2, rs1, f3, rd);
      if (k < 50) return enc_u(r, rd, (k < 48) ? 7'h37 : 7'h17);
      if (k < 58) return enc_b(off, rs2, rs1, (f3 == 2 || f3 == 3) ? f3 + 2 : f3);
      if (k < 62) return enc_j(off, rd);
      if (k < 65) return enc_i(int'($urandom_range(0, 4095)), rs1, 0, rd, 7'h67);
      if (k < 85) return enc_csr(12'hF02, rs1, rd);
      if (k < 90) return enc_csr(12'hF00, rs1, rd);
      if (k < 93) return enc_csr(12'h300, rs1, rd);
      if (k < 95) return {r[31:15], 3'd0, r[11:7], 7'h73};
      return {r[31:7], (k < 97) ? 7'h7F : 7'h03};
   endfunction

   initial begin
      logic [31:0] exp_log [6] = '{32'h8, 32'h0, 32'h1C, 32'h1234, 32'hFABCDE00, 32'h1};
      for (int w = 0; w < NW; w++) mem[w] = 32'h13;
      mem[0]  = enc_i(5, 0, 0, 1, 7'h13);
      mem[1]  = enc_i(3, 1, 0, 2, 7'h13);
      mem[2]  = enc_csr(12'hF02, 2, 0);
      mem[3]  = enc_b(8, 0, 0, 0);
      mem[4]  = enc_i(1, 0, 0, 7, 7'h13);
      mem[5]  = enc_csr(12'hF02, 7, 0);
      mem[6]  = enc_j(16, 1);
      mem[7]  = enc_csr(12'hF02, 1, 0);
      mem[8]  = enc_j(16, 0);
      mem[10] = enc_i(0, 1, 0, 0, 7'h67);
      mem[12] = enc_csr(12'hF00, 0, 5);
      mem[13] = enc_csr(12'hF02, 5, 0);
      mem[14] = enc_u(32'hABCDE, 3, 7'h37);
      mem[15] = enc_i(12'h404, 3, 5, 4, 7'h13);
      mem[16] = enc_r(0, 3, 0, 3, 6);
      mem[17] = enc_csr(12'hF02, 4, 0);
      mem[18] = 32'h0000007F;
      mem[19] = enc_csr(12'hF02, 6, 0);
      mem[20] = enc_j(0, 0);
      m_reset();
      cycle(1'b0, 32'h1234);
      for (int c = 0; c < 45; c++) cycle(1'b1, 32'h1234);
      chk("dir_we_pulses", gpio_log.size(), 6);
      for (int n = 0; n < 6 && n < gpio_log.size(); n++) chk("dir_gpio_seq", gpio_log[n], exp_log[n]);
      chk("dir_illegal_cnt", ill_cnt, 1);
      for (int p = 0; p < 4; p++) begin
         cycle(1'b0, $urandom);
         for (int w = 0; w < NW; w++) mem[w] = gen();
         for (int c = 0; c < 300; c++) begin
            cycle(!(c == 150 || c == 151 || $urandom_range(0, 199) == 0), $urandom);
            if (c == 151) begin
               chk("rst_gpio_out", gpio_out, 32'h0);
               chk("rst_imem_addr", 32'(imem_addr), 32'h0);
               chk("rst_gpio_we", 32'(gpio_out_we), 32'h0);
            end
         end
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
